rom_arbiter: RTL and testbench

Two-port round-robin read arbiter that shares a single bootrom read bus (16-bit address, 8-bit data, fixed read latency) between two requesters, e.g. CPU instruction fetch (port 0) and a debug/DMA reader (port 1). Sits between the requesters and the ROM address-decode wrapper, driving its enable and address and routing returned data back to the originating port. Reads are pipelined: one grant per cycle, with up to READ_LATENCY reads in flight, each tagged with its source port.

---
 rtl/rom_arbiter.sv | 100 ++++++++++
 tb/tb_rom_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Two-port round-robin read arbiter in front of a fixed-latency bootrom bus.
// Grants are combinational; each issued read is tagged and routed back to its port.
module rom_arbiter #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clka,
    input  logic        rsta,
    input  logic        ena,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [7:0]  rdata0,
    output logic [7:0]  rdata1,
    output logic        mem_en,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_dout
);

    localparam int STAGES = READ_LATENCY + 1;

    logic                last_q, last_d;
    logic [STAGES-1:0]   vld_q, vld_d;
    logic [STAGES-1:0]   tag_q, tag_d;
    logic [7:0]          rdata0_q, rdata0_d;
    logic [7:0]          rdata1_q, rdata1_d;
    logic                gnt0_d, gnt1_d;
    logic                cap_vld, cap_tag;

    // Arbitration: the port that did not win last time takes a tie.
    always_comb begin
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        if (!rsta && ena) begin
            if (req0 && req1) begin
                if (last_q) gnt0_d = 1'b1;
                else        gnt1_d = 1'b1;
            end else if (req0) begin
                gnt0_d = 1'b1;
            end else if (req1) begin
                gnt1_d = 1'b1;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt0_d)      last_d = 1'b0;
        else if (gnt1_d) last_d = 1'b1;
    end

    assign gnt0     = gnt0_d;
    assign gnt1     = gnt1_d;
    assign mem_en   = gnt0_d | gnt1_d;
    assign mem_addr = gnt0_d ? addr0 : (gnt1_d ? addr1 : 16'h0000);

    // In-flight tracker: stage k holds the read issued k+1 cycles ago.
    assign vld_d = {vld_q[STAGES-2:0], mem_en};
    assign tag_d = {tag_q[STAGES-2:0], gnt1_d};

    // mem_dout is valid while the read sits in stage READ_LATENCY-1.
    assign cap_vld = vld_q[READ_LATENCY-1];
    assign cap_tag = tag_q[READ_LATENCY-1];

    always_comb begin
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (cap_vld && !cap_tag) rdata0_d = mem_dout;
        if (cap_vld &&  cap_tag) rdata1_d = mem_dout;
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            last_q   <= 1'b1;
            vld_q    <= '0;
            rdata0_q <= 8'h00;
            rdata1_q <= 8'h00;
        end else begin
            last_q   <= last_d;
            vld_q    <= vld_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Port tags only matter alongside a set valid bit, so they need no reset.
    always_ff @(posedge clka) begin
        tag_q <= tag_d;
    end

    assign rvalid0 = vld_q[READ_LATENCY] & ~tag_q[READ_LATENCY];
    assign rvalid1 = vld_q[READ_LATENCY] &  tag_q[READ_LATENCY];
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: three instances (READ_LATENCY 1..3) share one directed
// stimulus stream; a monitor checks grants each cycle and pops expected responses.
module tb_rom_arbiter;

    typedef struct {
        int         due;
        logic       port;
        logic [7:0] data;
    } resp_t;

    logic        clk;
    logic        rsta, ena, req0, req1;
    logic [15:0] addr0, addr1;
    int          exp_g;
    int          cyc;
    int          ncmp, nfail;
    logic        rst_seen;

    logic        gnt0_w   [3];
    logic        gnt1_w   [3];
    logic        rvalid0_w[3];
    logic        rvalid1_w[3];
    logic [7:0]  rdata0_w [3];
    logic [7:0]  rdata1_w [3];
    logic        mem_en_w [3];
    logic [15:0] mem_addr_w[3];
    logic [7:0]  mem_dout_w[3];

    resp_t       sb_q [3][$];
    logic [7:0]  mrd0 [3];
    logic [7:0]  mrd1 [3];

    function automatic logic [7:0] rom_f(input logic [15:0] a);
        if (a == 16'h0010) return 8'hA5;
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = g + 1;
        logic [15:0] pa [L];

        rom_arbiter #(.READ_LATENCY(L)) dut (
            .clka    (clk),
            .rsta    (rsta),
            .ena     (ena),
            .req0    (req0),
            .req1    (req1),
            .addr0   (addr0),
            .addr1   (addr1),
            .gnt0    (gnt0_w[g]),
            .gnt1    (gnt1_w[g]),
            .rvalid0 (rvalid0_w[g]),
            .rvalid1 (rvalid1_w[g]),
            .rdata0  (rdata0_w[g]),
            .rdata1  (rdata1_w[g]),
            .mem_en  (mem_en_w[g]),
            .mem_addr(mem_addr_w[g]),
            .mem_dout(mem_dout_w[g])
        );

        // ROM model: data for an address issued in cycle T is on the bus in T+L.
        always @(posedge clk) begin
            pa[0] <= mem_addr_w[g];
            for (int k = 1; k < L; k++) pa[k] <= pa[k-1];
        end
        assign mem_dout_w[g] = rom_f(pa[L-1]);
    end

    // Monitor
    always @(negedge clk) begin
        logic [18:0] act, expv;
        logic        ev0, ev1;
        resp_t       r;
        for (int i = 0; i < 3; i++) begin
            act = {gnt0_w[i], gnt1_w[i], mem_en_w[i], mem_addr_w[i]};
            if (exp_g == 0)      expv = {1'b1, 1'b0, 1'b1, addr0};
            else if (exp_g == 1) expv = {1'b0, 1'b1, 1'b1, addr1};
            else                 expv = 19'h0;
            ncmp++;
            if (act !== expv) begin
                nfail++;
                $display("FAIL grant L=%0d cyc=%0d: got {g0,g1,en,addr}=%h want %h", i + 1, cyc, act, expv);
            end
            if (rst_seen) begin
                ev0 = 1'b0;
                ev1 = 1'b0;
                if (sb_q[i].size() > 0 && sb_q[i][0].due == cyc) begin
                    r = sb_q[i].pop_front();
                    if (r.port) begin ev1 = 1'b1; mrd1[i] = r.data; end
                    else        begin ev0 = 1'b1; mrd0[i] = r.data; end
                end
                ncmp++;
                if ({rvalid0_w[i], rvalid1_w[i]} !== {ev0, ev1}) begin
                    nfail++;
                    $display("FAIL rvalid L=%0d cyc=%0d: got {rv0,rv1}=%b%b want %b%b", i + 1, cyc,
                             rvalid0_w[i], rvalid1_w[i], ev0, ev1);
                end
                ncmp++;
                if (rdata0_w[i] !== mrd0[i]) begin
                    nfail++;
                    $display("FAIL rdata0 L=%0d cyc=%0d: got %h want %h", i + 1, cyc, rdata0_w[i], mrd0[i]);
                end
                ncmp++;
                if (rdata1_w[i] !== mrd1[i]) begin
                    nfail++;
                    $display("FAIL rdata1 L=%0d cyc=%0d: got %h want %h", i + 1, cyc, rdata1_w[i], mrd1[i]);
                end
            end
        end
        if (rsta) begin
            rst_seen = 1'b1;
            for (int i = 0; i < 3; i++) begin
                sb_q[i].delete();
                mrd0[i] = 8'h00;
                mrd1[i] = 8'h00;
            end
        end
    end

    task automatic step(input logic r, input logic e, input logic q0, input logic q1,
                        input logic [15:0] x0, input logic [15:0] x1, input int eg);
        @(posedge clk);
        #1;
        cyc++;
        rsta  = r;
        ena   = e;
        req0  = q0;
        req1  = q1;
        addr0 = x0;
        addr1 = x1;
        exp_g = eg;
        if (eg >= 0) begin
            for (int i = 0; i < 3; i++)
                sb_q[i].push_back('{due: cyc + i + 2, port: eg[0], data: rom_f(eg == 0 ? x0 : x1)});
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, -1);
    endtask

    initial begin
        clk = 1'b0; rsta = 1'b1; ena = 1'b1; req0 = 1'b0; req1 = 1'b0;
        addr0 = 16'h0; addr1 = 16'h0; exp_g = -1; cyc = 0;
        ncmp = 0; nfail = 0; rst_seen = 1'b0;

        // Reset, with requests held high to show grants stay suppressed
        step(1, 1, 0, 0, 16'h0000, 16'h0000, -1);
        step(1, 1, 1, 1, 16'h0010, 16'h0100, -1);

        // Single read from port 0
        step(0, 1, 1, 0, 16'h0010, 16'h0000, 0);
        idle(4);

        // Contention after a fresh reset: 0,1,0,1,0,1
        step(1, 1, 0, 0, 16'h0000, 16'h0000, -1);
        for (int k = 0; k < 6; k++) step(0, 1, 1, 1, 16'h0000, 16'h0100, k % 2);
        idle(4);

        // Port-0 burst, then ena low with both requesting while the burst drains
        for (int k = 0; k < 4; k++) step(0, 1, 1, 0, 16'h0020 + 16'(k), 16'h0000, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 1, 1, 16'h0030, 16'h0130, -1);
        step(0, 1, 1, 1, 16'h0030, 16'h0130, 1);
        idle(4);

        // Tag routing: port 0 then port 1 on consecutive cycles
        step(0, 1, 1, 1, 16'h0040, 16'h0140, 0);
        step(0, 1, 0, 1, 16'h0000, 16'h0140, 1);
        idle(4);

        // Reset mid-flight after a port-1 grant; first tie afterwards goes to port 0
        step(0, 1, 0, 1, 16'h0000, 16'h0155, 1);
        step(1, 1, 1, 1, 16'h0050, 16'h0150, -1);
        step(0, 1, 1, 1, 16'h0050, 16'h0150, 0);
        step(0, 1, 0, 1, 16'h0000, 16'h0150, 1);
        idle(5);

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
